// File: rtl/mpeg_bitstream_reader.sv
// MPEG input-stream bit reader: fetches FIFO RAM words into a 64-bit left-aligned bit buffer.
// Define MPEG_START_CODE_SEARCH_EN to enable the hardware start-code search.
module mpeg_bitstream_reader #(
  parameter int unsigned FETCH_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] raddr,
  input  logic [31:0] q,
  input  logic [13:0] wptr,
  output logic [11:0] rd_word_ptr,
  output logic [31:0] bits,
  output logic [6:0]  bit_count,
  output logic        bits_valid,
  input  logic        shift_en,
  input  logic [5:0]  shift_len,
  input  logic        byte_align,
  input  logic        flush,
  output logic        underflow,
  input  logic        search_start,
  output logic        search_busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] sbuf_q, sbuf_d, sbuf_s;
  logic [6:0]  cnt_q, cnt_d, cnt_s, sh;
  logic [10:0] raddr_q, raddr_d;
  logic [11:0] ptr_q, ptr_d;
  logic        uflow_q, uflow_d;
  logic        busy_q, busy_d;
  logic        align_req, shift_req;
  logic [5:0]  len_req;
  logic [31:0] swapped;
  logic        avail;

  assign swapped = {q[7:0], q[15:8], q[23:16], q[31:24]};
  assign avail   = (wptr[13:2] != ptr_q);

`ifdef MPEG_START_CODE_SEARCH_EN
  // While searching, the search sequencer owns the align/shift controls.
  always_comb begin
    align_req = byte_align;
    shift_req = shift_en;
    len_req   = shift_len;
    busy_d    = busy_q | search_start;
    if (busy_q) begin
      align_req = 1'b0;
      shift_req = 1'b0;
      len_req   = 6'd8;
      if (cnt_q[2:0] != 3'd0) begin
        align_req = 1'b1;
      end else if (cnt_q >= 7'd32) begin
        if (sbuf_q[63:40] == 24'h000001) busy_d = 1'b0;
        else                             shift_req = 1'b1;
      end
    end
    if (flush) busy_d = 1'b0;
  end
`else
  logic unused_search_start;
  assign unused_search_start = search_start;
  assign align_req = byte_align;
  assign shift_req = shift_en;
  assign len_req   = shift_len;
  assign busy_d    = 1'b0;
`endif

  always_comb begin
    sh      = '0;
    uflow_d = uflow_q;
    if (align_req) begin
      sh = {4'd0, cnt_q[2:0]};
    end else if (shift_req) begin
      if (len_req == 6'd0 || {1'b0, len_req} > cnt_q) uflow_d = 1'b1;
      else                                            sh = {1'b0, len_req};
    end
    sbuf_s  = sbuf_q << sh;
    cnt_s   = cnt_q - sh;

    sbuf_d  = sbuf_s;
    cnt_d   = cnt_s;
    state_d = state_q;
    ptr_d   = ptr_q;
    raddr_d = raddr_q;
    if (flush) begin
      sbuf_d  = '0;
      cnt_d   = '0;
      uflow_d = 1'b0;
      state_d = ST_IDLE;
      ptr_d   = wptr[13:2] + {11'd0, |wptr[1:0]};
    end else if (state_q == ST_WAIT) begin
      sbuf_d  = sbuf_s | ({swapped, 32'd0} >> cnt_s);
      cnt_d   = cnt_s + 7'd32;
      state_d = ST_IDLE;
    end else if (avail && cnt_s <= 7'd32) begin
      raddr_d = ptr_q[10:0];
      ptr_d   = ptr_q + 12'd1;
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sbuf_q  <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      ptr_q   <= '0;
      uflow_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      ptr_q   <= ptr_d;
      uflow_q <= uflow_d;
      busy_q  <= busy_d;
    end
  end

  // The address leaves in the issue cycle so the RAM's single read cycle lands in ST_WAIT.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == ST_WAIT) assert (FETCH_LATENCY == 1);
  end

  assign raddr       = raddr_d;
  assign rd_word_ptr = ptr_q;
  assign bits        = sbuf_q[63:32];
  assign bit_count   = cnt_q;
  assign bits_valid  = (cnt_q >= 7'd32);
  assign underflow   = uflow_q;
  assign search_busy = busy_q;

endmodule

// File: tb/tb_mpeg_bitstream_reader.sv
// Scoreboard bench for mpeg_bitstream_reader: stimulus queues expected states and fetch
// addresses, a monitor pops and compares them as the DUT presents them.
module tb_mpeg_bitstream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] raddr;
  logic [31:0] q;
  logic [13:0] wptr;
  logic [11:0] rd_word_ptr;
  logic [31:0] bits;
  logic [6:0]  bit_count;
  logic        bits_valid;
  logic        shift_en;
  logic [5:0]  shift_len;
  logic        byte_align;
  logic        flush;
  logic        underflow;
  logic        search_start;
  logic        search_busy;

  mpeg_bitstream_reader #(.FETCH_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .raddr(raddr), .q(q), .wptr(wptr),
    .rd_word_ptr(rd_word_ptr), .bits(bits), .bit_count(bit_count),
    .bits_valid(bits_valid), .shift_en(shift_en), .shift_len(shift_len),
    .byte_align(byte_align), .flush(flush), .underflow(underflow),
    .search_start(search_start), .search_busy(search_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) q <= mem[raddr];

  typedef struct packed {
    int unsigned at;
    logic [31:0] bits;
    logic [6:0]  cnt;
    logic        uflow;
    logic [11:0] ptr;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  string       exp_name[$];
  logic [10:0] addr_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        flush_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    flush_at_edge <= flush;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [31:0] b, input logic [6:0] c,
                            input logic u, input logic [11:0] p, input logic bz);
    exp_t e;
    e.at = cyc; e.bits = b; e.cnt = c; e.uflow = u; e.ptr = p; e.busy = bz;
    exp_q.push_back(e);
    exp_name.push_back(nm);
  endtask

  // Monitor: fetch addresses on every pointer advance, states at their scheduled cycle.
  initial begin
    logic [11:0] last_ptr;
    logic [10:0] a;
    exp_t        e;
    string       nm;
    last_ptr = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && rd_word_ptr !== last_ptr && !flush_at_edge) begin
        n_checks++;
        if (addr_q.size() == 0) begin
          $display("FAIL fetch_addr: unexpected fetch raddr=%0d ptr=%h", raddr, rd_word_ptr);
        end else begin
          a = addr_q.pop_front();
          if (raddr === a) n_pass++;
          else $display("FAIL fetch_addr: raddr=%0d expected %0d", raddr, a);
        end
      end
      last_ptr = rd_word_ptr;
      while (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
        e  = exp_q.pop_front();
        nm = exp_name.pop_front();
        n_checks++;
        if (e.at == cyc && bits === e.bits && bit_count === e.cnt &&
            bits_valid === (e.cnt >= 7'd32) && underflow === e.uflow &&
            rd_word_ptr === e.ptr && search_busy === e.busy) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got bits=%h cnt=%0d valid=%b uflow=%b ptr=%h busy=%b; expected bits=%h cnt=%0d valid=%b uflow=%b ptr=%h busy=%b (cyc %0d/%0d)",
                   nm, bits, bit_count, bits_valid, underflow, rd_word_ptr, search_busy,
                   e.bits, e.cnt, (e.cnt >= 7'd32), e.uflow, e.ptr, e.busy, cyc, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; wptr = '0; shift_en = 1'b0; shift_len = '0;
    byte_align = 1'b0; flush = 1'b0; search_start = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    step(); step();
    expect_now("reset", 32'h0, 7'd0, 1'b0, 12'h000, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // First word: stream 00 00 01 B3
    mem[0] = 32'hB301_0000; wptr = 14'd4; addr_q.push_back(11'd0);
    step(); expect_now("fetch_issue", 32'h0, 7'd0, 1'b0, 12'h001, 1'b0);
    step(); expect_now("first_word", 32'h000001B3, 7'd32, 1'b0, 12'h001, 1'b0);
    step(); expect_now("idle_empty", 32'h000001B3, 7'd32, 1'b0, 12'h001, 1'b0);

    // Shift 12 concurrent with the next word's fetch: 12 34 56 78
    mem[1] = 32'h7856_3412; wptr = 14'd8; addr_q.push_back(11'd1);
    shift_en = 1'b1; shift_len = 6'd12;
    step(); shift_en = 1'b0;
    expect_now("shift12", 32'h001B3000, 7'd20, 1'b0, 12'h002, 1'b0);
    step(); expect_now("shift12_refill", 32'h001B3123, 7'd52, 1'b0, 12'h002, 1'b0);

    byte_align = 1'b1;
    step(); expect_now("byte_align", 32'h01B31234, 7'd48, 1'b0, 12'h002, 1'b0);
    shift_en = 1'b1; shift_len = 6'd8;
    step(); byte_align = 1'b0; shift_en = 1'b0;
    expect_now("align_noop_prio", 32'h01B31234, 7'd48, 1'b0, 12'h002, 1'b0);

    shift_en = 1'b1; shift_len = 6'd32;
    step(); expect_now("shift32", 32'h56780000, 7'd16, 1'b0, 12'h002, 1'b0);
    shift_len = 6'd11;
    step(); expect_now("shift11", 32'hC0000000, 7'd5, 1'b0, 12'h002, 1'b0);
    shift_len = 6'd8;
    step(); shift_en = 1'b0;
    expect_now("underflow", 32'hC0000000, 7'd5, 1'b1, 12'h002, 1'b0);
    flush = 1'b1; wptr = 14'h0006;
    step(); flush = 1'b0; wptr = 14'h0008;
    expect_now("flush_partial", 32'h0, 7'd0, 1'b0, 12'h002, 1'b0);

    // Wrap: fetch word 2047 then word 0 (AA BB CC DD, 00 00 01 B3)
    mem[2047] = 32'hDDCC_BBAA;
    flush = 1'b1; wptr = 14'h1FFC;
    step(); flush = 1'b0; wptr = 14'h2004;
    expect_now("flush_to_7ff", 32'h0, 7'd0, 1'b0, 12'h7FF, 1'b0);
    addr_q.push_back(11'd2047); addr_q.push_back(11'd0);
    step(); expect_now("wrap_fetch_2047", 32'h0, 7'd0, 1'b0, 12'h800, 1'b0);
    step(); expect_now("wrap_word_a", 32'hAABBCCDD, 7'd32, 1'b0, 12'h800, 1'b0);
    step(); expect_now("wrap_fetch_0", 32'hAABBCCDD, 7'd32, 1'b0, 12'h801, 1'b0);
    step(); expect_now("wrap_word_b", 32'hAABBCCDD, 7'd64, 1'b0, 12'h801, 1'b0);
    step(); expect_now("wrap_stall", 32'hAABBCCDD, 7'd64, 1'b0, 12'h801, 1'b0);

    shift_en = 1'b1; shift_len = 6'd0;
    step(); expect_now("zero_len", 32'hAABBCCDD, 7'd64, 1'b1, 12'h801, 1'b0);
    shift_len = 6'd32;
    step(); expect_now("shift32_b", 32'h000001B3, 7'd32, 1'b1, 12'h801, 1'b0);
    step(); shift_en = 1'b0;
    expect_now("shift_all", 32'h0, 7'd0, 1'b1, 12'h801, 1'b0);

    // Reset while a fetch is in flight
    wptr = 14'h2008;
    step(); reset_n = 1'b0;
    expect_now("reset_mid_fetch", 32'h0, 7'd0, 1'b0, 12'h000, 1'b0);
    step(); reset_n = 1'b1; wptr = 14'h0000;
    step(); expect_now("no_insert_after_reset", 32'h0, 7'd0, 1'b0, 12'h000, 1'b0);

`ifdef MPEG_START_CODE_SEARCH_EN
    // Stream FF 00 00 01 BA 11 22 33
    mem[16] = 32'h0100_00FF; mem[17] = 32'h3322_11BA;
    flush = 1'b1; wptr = 14'h0040;
    step(); flush = 1'b0; wptr = 14'h0048;
    expect_now("flush_search", 32'h0, 7'd0, 1'b0, 12'h010, 1'b0);
    addr_q.push_back(11'd16); addr_q.push_back(11'd17);
    step(); expect_now("sc_fetch_a", 32'h0, 7'd0, 1'b0, 12'h011, 1'b0);
    step(); expect_now("sc_word_a", 32'hFF000001, 7'd32, 1'b0, 12'h011, 1'b0);
    step(); expect_now("sc_fetch_b", 32'hFF000001, 7'd32, 1'b0, 12'h012, 1'b0);
    step(); expect_now("sc_word_b", 32'hFF000001, 7'd64, 1'b0, 12'h012, 1'b0);
    search_start = 1'b1;
    step(); search_start = 1'b0;
    expect_now("search_busy", 32'hFF000001, 7'd64, 1'b0, 12'h012, 1'b1);
    step(); expect_now("search_step", 32'h000001BA, 7'd56, 1'b0, 12'h012, 1'b1);
    step(); expect_now("search_found", 32'h000001BA, 7'd56, 1'b0, 12'h012, 1'b0);
`else
    search_start = 1'b1;
    step(); search_start = 1'b0;
    expect_now("search_disabled", 32'h0, 7'd0, 1'b0, 12'h000, 1'b0);
`endif

    step(); step(); step();
    while (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got no check expected one at cyc %0d", exp_name.pop_front(), exp_q[0].at);
      void'(exp_q.pop_front());
    end
    while (addr_q.size() != 0) begin
      n_checks++;
      $display("FAIL fetch_missing: got no fetch expected raddr=%0d", addr_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
